// File: rtl/reg_dump_tx_pkg.sv
// Shared constants and state encoding for the end-of-run register dump transmitter.
package reg_dump_tx_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned SEL_W       = 5;
  localparam int unsigned FRAME_BYTES = 135;

  localparam logic [BYTE_W-1:0] SOF       = 8'hA5;
  localparam logic [BYTE_W-1:0] EOF       = 8'h5A;
  localparam logic [BYTE_W-1:0] REASON_PC = 8'h01;
  localparam logic [BYTE_W-1:0] REASON_TO = 8'h02;

  localparam logic [SEL_W-1:0] LAST_REG = 5'd31;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HDR,
    ST_CNT,
    ST_SEL,
    ST_CAP,
    ST_SEND,
    ST_TRL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/reg_dump_tx_if.sv
// Valid/ready byte stream from the dump framer towards the UART transmitter.
interface reg_dump_tx_if;
  import reg_dump_tx_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/reg_dump_tx_byte_serializer.sv
// Emits 1..4 bytes of a loaded word LSB-first over valid/ready; last_c marks the final acceptance.
module reg_dump_tx_byte_serializer
  import reg_dump_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        nbytes_m1,
  output logic              last_c,
  reg_dump_tx_if.master     tx
);

  logic [WORD_W-BYTE_W-1:0] shift;
  logic [1:0]               left;
  logic                     accept_c;

  assign accept_c = tx.tx_valid && tx.tx_ready;
  assign last_c   = accept_c && (left == 2'd0);

  // Byte 0 goes straight to the output register; the rest wait in shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift       <= '0;
      left        <= 2'd0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
    end else if (load) begin
      shift       <= word[WORD_W-1:BYTE_W];
      left        <= nbytes_m1;
      tx.tx_data  <= word[BYTE_W-1:0];
      tx.tx_valid <= 1'b1;
    end else if (accept_c) begin
      if (left == 2'd0) begin
        tx.tx_valid <= 1'b0;
      end else begin
        tx.tx_data <= shift[BYTE_W-1:0];
        shift      <= {8'h00, shift[WORD_W-BYTE_W-1:BYTE_W]};
        left       <= left - 2'd1;
      end
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// End-of-run observer: halts the core on PC match or timeout, then streams
// a framed dump (header, cycle count, x0..x31, trailer) as bytes.
module reg_dump_tx
  import reg_dump_tx_pkg::*;
#(
  parameter logic [WORD_W-1:0] HALT_PC    = 32'hF000_0100,
  parameter int unsigned       MAX_CYCLES = 1000,
  parameter int unsigned       CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [WORD_W-1:0] reg_data,
  output logic              cpu_halt,
  reg_dump_tx_if.master     tx,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic              halt_c;
  logic              pc_hit_c;
  logic [BYTE_W-1:0] reason_c;
  logic              load_c;
  logic [WORD_W-1:0] load_word_c;
  logic [1:0]        load_len_c;
  logic              last_c;

  assign pc_hit_c = (pc == HALT_PC);
  assign reason_c = pc_hit_c ? REASON_PC : REASON_TO;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_d;
  end

  // Next state plus serializer load requests; each sending state loads its
  // successor on the final acceptance so bytes can flow back to back.
  always_comb begin
    state_d     = state;
    halt_c      = 1'b0;
    load_c      = 1'b0;
    load_word_c = '0;
    load_len_c  = 2'd3;
    case (state)
      ST_RUN: begin
        halt_c = pc_hit_c || (cnt == LAST_CYC);
        if (halt_c) begin
          state_d     = ST_HDR;
          load_c      = 1'b1;
          load_word_c = {16'h0000, reason_c, SOF};
          load_len_c  = 2'd1;
        end
      end
      ST_HDR: begin
        if (last_c) begin
          state_d     = ST_CNT;
          load_c      = 1'b1;
          load_word_c = 32'(cnt);
        end
      end
      ST_CNT: begin
        if (last_c) state_d = ST_SEL;
      end
      ST_SEL: state_d = ST_CAP;
      ST_CAP: begin
        state_d     = ST_SEND;
        load_c      = 1'b1;
        load_word_c = reg_data;
      end
      ST_SEND: begin
        if (last_c) begin
          if (reg_sel == LAST_REG) begin
            state_d     = ST_TRL;
            load_c      = 1'b1;
            load_word_c = {24'h000000, EOF};
            load_len_c  = 2'd0;
          end else begin
            state_d = ST_SEL;
          end
        end
      end
      ST_TRL: begin
        if (last_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  // Cycle counter, register index and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      reg_sel  <= '0;
      cpu_halt <= 1'b0;
      done     <= 1'b0;
    end else begin
      if ((state == ST_RUN) && !halt_c) cnt <= cnt + CNT_W'(1);
      if ((state == ST_CNT) && last_c) begin
        reg_sel <= '0;
      end else if ((state == ST_SEND) && last_c && (reg_sel != LAST_REG)) begin
        reg_sel <= reg_sel + 5'd1;
      end
      cpu_halt <= (state_d != ST_RUN);
      done     <= (state_d == ST_DONE);
    end
  end

  reg_dump_tx_byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .word      (load_word_c),
    .nbytes_m1 (load_len_c),
    .last_c    (last_c),
    .tx        (tx)
  );

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: frame model built from the dump rules, checked every cycle.
module tb_reg_dump_tx;

  localparam logic [31:0] HALT_PC    = 32'hF000_0100;
  localparam int          MAX_CYCLES = 1000;
  localparam int          NBYTES     = 135;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] reg_data;
  logic [4:0]  reg_sel;
  logic        cpu_halt;
  logic        done;

  int cyc        = 0;
  int halt_at    = -1;
  int data_mode  = 0;
  int ready_mode = 0;
  int hc         = 0;
  bit chk_en     = 1'b0;

  int n_err    = 0;
  int n_checks = 0;
  int nacc     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx [NBYTES];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  reg_dump_tx_if tx ();

  reg_dump_tx #(
    .HALT_PC    (HALT_PC),
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .reg_sel  (reg_sel),
    .reg_data (reg_data),
    .cpu_halt (cpu_halt),
    .tx       (tx),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Core stand-in: PC walks forward and hits HALT_PC on cycle halt_at.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  assign pc = (cyc == halt_at) ? HALT_PC : 32'h0000_1000 + 32'(cyc) * 32'd4;
  assign reg_data = (data_mode == 1) ? ((reg_sel == 5'd31) ? 32'hDEAD_BEEF : 32'h0)
                                     : 32'({27'b0, reg_sel} * 32'd3);

  initial begin
    tx.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx.tx_ready = (ready_mode != 0) ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] reg_word(input int i, input int mode);
    if (mode == 1) return (i == 31) ? 32'hDEAD_BEEF : 32'h0;
    return 32'(i * 3);
  endfunction

  function automatic void build_frame(input int count, input logic [7:0] rsn, input int mode);
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(rsn);
    w = 32'(count);
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
    for (int i = 0; i < 32; i++) begin
      w = reg_word(i, mode);
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
    end
    exp_q.push_back(8'h5A);
  endfunction

  // Per-cycle compare against the frame model, halt/done timing and hold rules.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_halt", 32'(cpu_halt), 32'(cyc > hc));
      chk("done", 32'(done), 32'(nacc == NBYTES));
      if (prev_stall) begin
        chk("hold_valid", 32'(tx.tx_valid), 32'd1);
        chk("hold_data", 32'(tx.tx_data), 32'(prev_data));
      end
      if (tx.tx_valid && tx.tx_ready) begin
        if (nacc < exp_q.size()) begin
          chk($sformatf("byte%0d", nacc), 32'(tx.tx_data), 32'(exp_q[nacc]));
          rx[nacc] = tx.tx_data;
        end else begin
          n_checks++;
          n_err++;
          $display("FAIL extra_byte: got %h after %0d bytes, expected none", tx.tx_data, nacc);
        end
        nacc++;
      end
      prev_stall = tx.tx_valid && !tx.tx_ready;
      prev_data  = tx.tx_data;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_reg_sel"},  32'(reg_sel),     32'd0);
    chk({tag, "_cpu_halt"}, 32'(cpu_halt),    32'd0);
    chk({tag, "_tx_valid"}, 32'(tx.tx_valid), 32'd0);
    chk({tag, "_tx_data"},  32'(tx.tx_data),  32'd0);
    chk({tag, "_done"},     32'(done),        32'd0);
  endtask

  task automatic run_case(input string name, input int h_at, input int dmode, input int rmode,
                          input int abort_at, output bit aborted);
    bit fin;
    bit pc_wins;
    fin     = 1'b0;
    aborted = 1'b0;
    @(posedge clk); #1;
    chk_en     = 1'b0;
    rst        = 1'b1;
    halt_at    = h_at;
    data_mode  = dmode;
    ready_mode = rmode;
    @(posedge clk);
    @(negedge clk);
    check_reset({name, "_rst"});
    pc_wins = (h_at >= 0) && (h_at < MAX_CYCLES);
    hc = pc_wins ? h_at : MAX_CYCLES - 1;
    build_frame(hc, pc_wins ? 8'h01 : 8'h02, dmode);
    nacc       = 0;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(posedge clk); #1;
      if (abort_at >= 0 && nacc >= abort_at) begin
        chk_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset({name, "_abort"});
        aborted = 1'b1;
        fin     = 1'b1;
      end else if (done) begin
        fin = 1'b1;
      end
    end
    if (!fin) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: got %0d bytes, expected %0d and done", name, nacc, NBYTES);
      chk_en = 1'b0;
    end else if (!aborted) begin
      repeat (6) @(posedge clk);
      #1;
      chk({name, "_byte_count"}, 32'(nacc), 32'(NBYTES));
      chk({name, "_idle_valid"}, 32'(tx.tx_valid), 32'd0);
      chk({name, "_final_sel"}, 32'(reg_sel), 32'd31);
      chk_en = 1'b0;
    end
  endtask

  initial begin
    bit ab;

    run_case("pc", 37, 0, 0, -1, ab);
    chk("pc_sof",    32'(rx[0]),   32'hA5);
    chk("pc_reason", 32'(rx[1]),   32'h01);
    chk("pc_cnt0",   32'(rx[2]),   32'h25);
    chk("pc_cnt1",   32'(rx[3]),   32'h00);
    chk("pc_x0",     32'(rx[6]),   32'h00);
    chk("pc_x1",     32'(rx[10]),  32'h03);
    chk("pc_x31",    32'(rx[130]), 32'h5D);
    chk("pc_eof",    32'(rx[134]), 32'h5A);

    run_case("to", -1, 0, 0, -1, ab);
    chk("to_reason", 32'(rx[1]), 32'h02);
    chk("to_cnt0",   32'(rx[2]), 32'hE7);
    chk("to_cnt1",   32'(rx[3]), 32'h03);
    chk("to_cnt2",   32'(rx[4]), 32'h00);
    chk("to_cnt3",   32'(rx[5]), 32'h00);

    run_case("both", 999, 0, 0, -1, ab);
    chk("both_reason", 32'(rx[1]), 32'h01);
    chk("both_cnt0",   32'(rx[2]), 32'hE7);
    chk("both_cnt1",   32'(rx[3]), 32'h03);

    run_case("rand", 37, 0, 1, -1, ab);
    chk("rand_cnt0", 32'(rx[2]),   32'h25);
    chk("rand_x31",  32'(rx[130]), 32'h5D);
    chk("rand_eof",  32'(rx[134]), 32'h5A);

    run_case("abort", 37, 0, 1, 59, ab);
    chk("abort_taken", 32'(ab), 32'd1);
    run_case("rerun", 37, 0, 1, -1, ab);
    chk("rerun_sof",    32'(rx[0]),   32'hA5);
    chk("rerun_reason", 32'(rx[1]),   32'h01);
    chk("rerun_eof",    32'(rx[134]), 32'h5A);

    run_case("beef", 37, 1, 0, -1, ab);
    chk("beef_x0",  32'(rx[6]),   32'h00);
    chk("beef_b0",  32'(rx[130]), 32'hEF);
    chk("beef_b1",  32'(rx[131]), 32'hBE);
    chk("beef_b2",  32'(rx[132]), 32'hAD);
    chk("beef_b3",  32'(rx[133]), 32'hDE);
    chk("beef_eof", 32'(rx[134]), 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
